fifo_wr_arbiter: RTL and testbench

//  Round-robin write arbiter sharing one 8-bit, 10-entry FIFO (wr/din/housefull) among NREQ producers.

---
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 130 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the producers, the arbiter and the FIFO write port.
// The master modport is the arbiter's view; slave is the producer/FIFO view.
interface fifo_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int OW   = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    gnt;
    logic               fifo_wr;
    logic [DW-1:0]      fifo_din;
    logic               fifo_full;
    logic               busy;
    logic [OW-1:0]      owner;

    modport master (
        input  req, req_data, req_last, fifo_full,
        output gnt, fifo_wr, fifo_din, busy, owner
    );

    modport slave (
        output req, req_data, req_last, fifo_full,
        input  gnt, fifo_wr, fifo_din, busy, owner
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NREQ producers.
// A grant lasts until the packet ends, the burst limit is hit or the producer
// withdraws; every write is gated on the FIFO full flag so nothing is dropped.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4,
    parameter int OW        = 2
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.master bus
);

    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    logic [1:0]      state_q, state_n;
    logic [NREQ-1:0] gnt_q, gnt_n;
    logic [OW-1:0]   owner_q, owner_n;
    logic [3:0]      cnt_q, cnt_n;

    logic [IW-1:0]   own_idx;
    logic [IW-1:0]   pick;
    logic [DW-1:0]   lanes [NREQ];
    logic            req_own;
    logic            last_own;
    logic            acc;

    assign own_idx  = owner_q[IW-1:0];
    assign req_own  = bus.req[own_idx];
    assign last_own = bus.req_last[own_idx];
    assign acc      = (state_q == S_GRANT) & req_own & ~bus.fifo_full;

    // Split the flat producer data bus into one lane per producer
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            lanes[i] = bus.req_data[i*DW +: DW];
        end
    end

    // Round-robin pick: nearest requester after the last owner wins, the last owner itself comes last
    always_comb begin
        int c;
        pick = own_idx;
        c    = 0;
        for (int k = NREQ; k >= 1; k--) begin
            c = (int'(own_idx) + k) % NREQ;
            if (bus.req[c[IW-1:0]]) begin
                pick = c[IW-1:0];
            end
        end
    end

    // Next-state logic for the grant FSM, burst counter and owner
    always_comb begin
        state_n = state_q;
        gnt_n   = gnt_q;
        owner_n = owner_q;
        cnt_n   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_n     = S_GRANT;
                    gnt_n       = '0;
                    gnt_n[pick] = 1'b1;
                    owner_n     = OW'(pick);
                    cnt_n       = '0;
                end
            end
            S_GRANT: begin
                if (!req_own) begin
                    state_n = S_IDLE;
                    gnt_n   = '0;
                    cnt_n   = '0;
                end else if (bus.fifo_full) begin
                    state_n = S_STALL;
                end else if (last_own || (cnt_q == LAST_BEAT)) begin
                    state_n = S_IDLE;
                    gnt_n   = '0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 4'd1;
                end
            end
            S_STALL: begin
                if (!bus.fifo_full) begin
                    state_n = S_GRANT;
                end else if (!req_own) begin
                    state_n = S_IDLE;
                    gnt_n   = '0;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
                gnt_n   = '0;
                cnt_n   = '0;
            end
        endcase
    end

    // State registers; reset parks the owner on the last producer so producer 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            owner_q <= OW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            gnt_q   <= gnt_n;
            owner_q <= owner_n;
            cnt_q   <= cnt_n;
        end
    end

    // A word presented while reset is asserted is never written
    assign bus.fifo_wr  = acc & ~rst;
    assign bus.fifo_din = lanes[own_idx];
    assign bus.gnt      = gnt_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.owner    = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer queues and a 10-entry FIFO model drive
// the DUT, expected writes go into a scoreboard popped by a monitor process.
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;
    localparam int OW        = 2;
    localparam int DEPTH     = 10;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    typedef struct {
        int            own;
        logic [DW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW), .OW(OW)) bus ();

    fifo_wr_arbiter #(
        .NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST), .OW(OW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    word_t pq [NREQ][$];
    exp_t  expq[$];

    int   fcount     = 0;
    logic rd_en      = 1'b1;
    logic force_full = 1'b0;

    int errors   = 0;
    int checks   = 0;
    int wr_cnt   = 0;
    int cyc_cnt  = 0;
    int first_wr = -1;
    int last_wr  = -1;

    logic [NREQ-1:0]    m_req;
    logic [NREQ-1:0]    m_last;
    logic [NREQ*DW-1:0] m_data;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, want);
        end
    endtask

    task automatic applyStimulus(input int p, input logic [DW-1:0] d, input logic l);
        word_t w;
        w.d = d;
        w.l = l;
        pq[p].push_back(w);
    endtask

    task automatic expectWrite(input int own, input logic [DW-1:0] d);
        exp_t e;
        e.own = own;
        e.d   = d;
        expq.push_back(e);
    endtask

    // advance to the quiet point of the next cycle (inputs driven, models updated)
    task automatic cycle();
        @(negedge clk);
        #3;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while (expq.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        checkOutput({name, " drained"}, expq.size(), 0);
    endtask

    task automatic waitWrites(input string name, input int target, input int budget);
        int n = 0;
        while (wr_cnt < target && n < budget) begin
            cycle();
            n++;
        end
        checkOutput({name, " write count"}, wr_cnt, target);
    endtask

    // Producers and FIFO model: drive at negedge, observe the write decision 1ns later
    initial begin
        forever begin
            @(negedge clk);
            m_req  = '0;
            m_last = '0;
            m_data = '0;
            for (int p = 0; p < NREQ; p++) begin
                if (pq[p].size() > 0) begin
                    m_req[p]            = 1'b1;
                    m_last[p]           = pq[p][0].l;
                    m_data[p*DW +: DW]  = pq[p][0].d;
                end
            end
            bus.req       = m_req;
            bus.req_last  = m_last;
            bus.req_data  = m_data;
            bus.fifo_full = (fcount >= DEPTH) || force_full;
            #1;
            for (int p = 0; p < NREQ; p++) begin
                if (bus.gnt[p] && bus.fifo_wr && pq[p].size() > 0) begin
                    void'(pq[p].pop_front());
                end
            end
            fcount = fcount + (bus.fifo_wr ? 1 : 0) - ((rd_en && fcount > 0) ? 1 : 0);
        end
    end

    // Monitor: every write strobe pops the scoreboard and compares grant, owner and data
    initial begin
        exp_t          e;
        logic [NREQ-1:0] oh;
        forever begin
            @(negedge clk);
            #2;
            cyc_cnt++;
            if (bus.fifo_wr) begin
                wr_cnt++;
                if (first_wr < 0) first_wr = cyc_cnt;
                last_wr = cyc_cnt;
                if (expq.size() == 0) begin
                    checkOutput("unexpected write", 32'(bus.fifo_wr), 32'd0);
                end else begin
                    e  = expq.pop_front();
                    oh = 4'b0001 << e.own;
                    checkOutput("write gnt/owner/data",
                                {18'd0, bus.gnt, bus.owner, bus.fifo_din},
                                {18'd0, oh, 2'(e.own), e.d});
                end
            end
        end
    end

    // Main directed sequence
    initial begin
        rst           = 1'b1;
        bus.req       = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.fifo_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #3;
        checkOutput("reset gnt", bus.gnt, 0);
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset owner", bus.owner, 3);
        checkOutput("reset fifo_wr", bus.fifo_wr, 0);

        // 1: sole producer 0, three-word packet
        $display("[TB] test 1: single packet from producer 0");
        applyStimulus(0, 8'hA1, 1'b0);
        applyStimulus(0, 8'hA2, 1'b0);
        applyStimulus(0, 8'hA3, 1'b1);
        expectWrite(0, 8'hA1);
        expectWrite(0, 8'hA2);
        expectWrite(0, 8'hA3);
        wr_cnt = 0;
        cycle();
        checkOutput("t1 idle no write", {bus.gnt, bus.fifo_wr}, 5'b0000_0);
        cycle();
        checkOutput("t1 grant+write", {bus.gnt, bus.fifo_wr}, 5'b0001_1);
        cycle();
        cycle();
        cycle();
        checkOutput("t1 back to idle", {bus.gnt, bus.busy}, 5'b0000_0);
        waitDrain("t1", 10);
        checkOutput("t1 writes", wr_cnt, 3);

        // 2: all four producers requesting, no packet ends
        $display("[TB] test 2: round robin with all requesting");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        for (int p = 0; p < NREQ; p++) begin
            for (int n = 0; n < 8; n++) begin
                applyStimulus(p, 8'((p << 4) | n), 1'b0);
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < NREQ; p++) begin
                for (int n = 0; n < 4; n++) begin
                    expectWrite(p, 8'((p << 4) | (r * 4 + n)));
                end
            end
        end
        wr_cnt   = 0;
        first_wr = -1;
        waitDrain("t2", 200);
        cycle();
        checkOutput("t2 writes", wr_cnt, 32);
        checkOutput("t2 span first..last write", last_wr - first_wr, 38);

        // 3: producer 0 stalled by full for three cycles mid-burst
        $display("[TB] test 3: full stall mid-burst");
        applyStimulus(0, 8'hB0, 1'b0);
        applyStimulus(0, 8'hB1, 1'b0);
        applyStimulus(0, 8'hB2, 1'b0);
        applyStimulus(0, 8'hB3, 1'b1);
        expectWrite(0, 8'hB0);
        expectWrite(0, 8'hB1);
        expectWrite(0, 8'hB2);
        expectWrite(0, 8'hB3);
        wr_cnt = 0;
        cycle();
        cycle();
        cycle();
        force_full = 1'b1;
        cycle();
        checkOutput("t3 no write into full", bus.fifo_wr, 0);
        cycle();
        checkOutput("t3 stall holds gnt", {bus.gnt, bus.fifo_wr, bus.busy}, 6'b0001_0_1);
        cycle();
        force_full = 1'b0;
        waitDrain("t3", 20);
        cycle();
        checkOutput("t3 writes", wr_cnt, 4);

        // 4: fill the FIFO with reads off
        $display("[TB] test 4: fill FIFO");
        fcount = 0;
        rd_en  = 1'b0;
        for (int n = 0; n < 11; n++) begin
            applyStimulus(1, 8'(8'hC0 + n), 1'b0);
            expectWrite(1, 8'(8'hC0 + n));
        end
        wr_cnt = 0;
        waitWrites("t4 first ten", 10, 100);
        repeat (5) cycle();
        checkOutput("t4 eleventh held", wr_cnt, 10);
        checkOutput("t4 full and busy", {bus.fifo_full, bus.busy}, 2'b11);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        waitDrain("t4", 30);
        cycle();
        checkOutput("t4 writes after read", wr_cnt, 11);
        checkOutput("t4 fifo level", fcount, 10);
        rd_en = 1'b1;
        repeat (12) cycle();

        // 5: producer 2 withdraws after two words
        $display("[TB] test 5: producer withdraw");
        fcount = 0;
        for (int n = 0; n < 4; n++) applyStimulus(2, 8'(8'hD0 + n), 1'b0);
        expectWrite(2, 8'hD0);
        expectWrite(2, 8'hD1);
        wr_cnt = 0;
        waitWrites("t5 two words", 2, 20);
        pq[2].delete();
        applyStimulus(3, 8'hE0, 1'b1);
        applyStimulus(0, 8'hF0, 1'b1);
        expectWrite(3, 8'hE0);
        expectWrite(0, 8'hF0);
        cycle();
        checkOutput("t5 withdraw no write", bus.fifo_wr, 0);
        cycle();
        checkOutput("t5 idle gap", bus.busy, 0);
        cycle();
        checkOutput("t5 resumes at 3", bus.gnt, 4'b1000);
        waitDrain("t5", 20);

        // 6: reset mid-burst while producer 2 owns the port
        $display("[TB] test 6: reset mid-burst");
        for (int n = 0; n < 4; n++) applyStimulus(2, 8'(8'h60 + n), 1'b0);
        applyStimulus(0, 8'h70, 1'b1);
        expectWrite(2, 8'h60);
        expectWrite(2, 8'h61);
        expectWrite(0, 8'h70);
        expectWrite(2, 8'h62);
        expectWrite(2, 8'h63);
        wr_cnt = 0;
        waitWrites("t6 two words", 2, 20);
        checkOutput("t6 owner before reset", bus.owner, 2);
        @(negedge clk);
        rst = 1'b1;
        #3;
        checkOutput("t6 no write in reset cycle", bus.fifo_wr, 0);
        @(negedge clk);
        rst = 1'b0;
        #3;
        checkOutput("t6 after reset", {bus.gnt, bus.busy, bus.fifo_wr, bus.owner}, 8'b0000_0_0_11);
        cycle();
        checkOutput("t6 first grant to 0", bus.gnt, 4'b0001);
        waitDrain("t6", 40);
        cycle();
        checkOutput("t6 writes", wr_cnt, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so a stuck run still reports
    initial begin
        #200000;
        errors++;
        checks++;
        $display("[TB] FAIL watchdog: got timeout, wanted completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
